// File: rtl/kirby_pkg.sv
// Shared types and constants for the Kirby action controller: action encoding,
// HID keycodes and per-action animation lengths.
package kirby_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    JUMP   = 3'd2,
    FALL   = 3'd3,
    INHALE = 3'd4
  } action_t;

  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_JUMP   = 8'h1A;
  localparam logic [7:0] KEY_INHALE = 8'h0D;

  localparam logic [3:0] FRAMES_IDLE   = 4'd2;
  localparam logic [3:0] FRAMES_WALK   = 4'd8;
  localparam logic [3:0] FRAMES_JUMP   = 4'd4;
  localparam logic [3:0] FRAMES_FALL   = 4'd2;
  localparam logic [3:0] FRAMES_INHALE = 4'd6;

  function automatic logic [3:0] frame_count(action_t a);
    case (a)
      IDLE:    return FRAMES_IDLE;
      WALK:    return FRAMES_WALK;
      JUMP:    return FRAMES_JUMP;
      FALL:    return FRAMES_FALL;
      INHALE:  return FRAMES_INHALE;
      default: return FRAMES_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/kirby_action_ctrl_if.sv
// Bundle between the keyboard/frame source and the Kirby sprite consumer.
interface kirby_action_ctrl_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] KirbyX;
  logic [9:0] KirbyY;
  logic [2:0] character_action_idx;
  logic [3:0] character_action_frame_idx;
  logic       facing_left;
  logic       frame_tick;

  modport master (
    output frame_clk, keycode,
    input  KirbyX, KirbyY, character_action_idx, character_action_frame_idx,
           facing_left, frame_tick
  );

  modport slave (
    input  frame_clk, keycode,
    output KirbyX, KirbyY, character_action_idx, character_action_frame_idx,
           facing_left, frame_tick
  );
endinterface

// File: rtl/kirby_frame_tick.sv
// Brings the asynchronous frame strobe into the clk domain and emits a single
// clk-wide pulse three edges after each frame_clk rising edge.
module kirby_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic frame_tick
);

  // sync[1:0] form the synchroniser, sync[2] holds the previous level for edge detect
  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= '0;
      frame_tick <= 1'b0;
    end else begin
      sync       <= {sync[1:0], frame_clk};
      frame_tick <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/kirby_action_ctrl.sv
// Per-frame action FSM, gravity/position integration and animation sequencing
// for the Kirby sprite; everything advances only on frame_tick.
module kirby_action_ctrl
  import kirby_pkg::*;
#(
  parameter logic [9:0] X_START   = 10'd210,
  parameter logic [9:0] Y_START   = 10'd240,
  parameter logic [9:0] X_MIN     = 10'd203,
  parameter logic [9:0] X_MAX     = 10'd436,
  parameter logic [9:0] Y_MIN     = 10'd152,
  parameter logic [9:0] Y_MAX     = 10'd327,
  parameter logic [9:0] MOVE_STEP = 10'd2,
  parameter logic [3:0] JUMP_V0   = 4'd8,
  parameter logic [3:0] FALL_VMAX = 4'd8,
  parameter logic [2:0] FRAME_DIV = 3'd4
) (
  input logic                Clk,
  input logic                Reset,
  kirby_action_ctrl_if.slave bus
);

  action_t    state, state_n;
  logic [9:0] x, x_n, y, y_n;
  logic [3:0] vy, vy_n, vf, vf_n;
  logic [3:0] frame, frame_n, cnt;
  logic [2:0] div, div_n;
  logic       facing, facing_n;
  logic       tick;
  logic       k_left, k_right, k_jump, k_inhale, k_horiz;
  logic [10:0] x_r, y_dn;

  kirby_frame_tick u_tick (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (bus.frame_clk),
    .frame_tick(tick)
  );

  assign k_left   = (bus.keycode == KEY_LEFT);
  assign k_right  = (bus.keycode == KEY_RIGHT);
  assign k_jump   = (bus.keycode == KEY_JUMP);
  assign k_inhale = (bus.keycode == KEY_INHALE);
  assign k_horiz  = k_left | k_right;

  assign x_r  = {1'b0, x} + {1'b0, MOVE_STEP};
  assign y_dn = {1'b0, y} + {7'd0, vf};
  assign cnt  = frame_count(state);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      x      <= X_START;
      y      <= Y_START;
      vy     <= '0;
      vf     <= '0;
      frame  <= '0;
      div    <= '0;
      facing <= 1'b0;
    end else if (tick) begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      vy     <= vy_n;
      vf     <= vf_n;
      frame  <= frame_n;
      div    <= div_n;
      facing <= facing_n;
    end
  end

  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    vy_n     = vy;
    vf_n     = vf;
    facing_n = facing;
    frame_n  = frame;
    div_n    = div;

    if (state != INHALE) begin
      if (k_left) begin
        // compare before subtracting so the left clamp never sees a wrapped value
        if ({1'b0, x} < ({1'b0, X_MIN} + {1'b0, MOVE_STEP})) x_n = X_MIN;
        else x_n = x - MOVE_STEP;
        facing_n = 1'b1;
      end else if (k_right) begin
        if (x_r > {1'b0, X_MAX}) x_n = X_MAX;
        else x_n = x_r[9:0];
        facing_n = 1'b0;
      end
    end

    case (state)
      IDLE, WALK: begin
        if (y < Y_MAX) begin
          state_n = FALL;
          vf_n    = 4'd1;
        end else if (k_jump) begin
          state_n = JUMP;
          vy_n    = JUMP_V0;
        end else if (k_inhale) begin
          state_n = INHALE;
        end else if (k_horiz) begin
          state_n = WALK;
        end else begin
          state_n = IDLE;
        end
      end
      JUMP: begin
        if ({1'b0, y} < ({1'b0, Y_MIN} + {7'd0, vy})) begin
          y_n     = Y_MIN;
          vy_n    = '0;
          state_n = FALL;
          vf_n    = 4'd1;
        end else begin
          y_n  = y - {6'd0, vy};
          vy_n = vy - 4'd1;
          if (vy == 4'd1) begin
            state_n = FALL;
            vf_n    = 4'd1;
          end
        end
      end
      FALL: begin
        if (y_dn >= {1'b0, Y_MAX}) begin
          y_n     = Y_MAX;
          vf_n    = '0;
          state_n = k_horiz ? WALK : IDLE;
        end else begin
          y_n  = y_dn[9:0];
          vf_n = (vf >= FALL_VMAX) ? FALL_VMAX : vf + 4'd1;
        end
      end
      INHALE: begin
        if (!k_inhale) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) begin
      frame_n = '0;
      div_n   = '0;
    end else if (div == FRAME_DIV - 3'd1) begin
      div_n = '0;
      if (frame == cnt - 4'd1) frame_n = (state == INHALE) ? frame : '0;
      else frame_n = frame + 4'd1;
    end else begin
      div_n = div + 3'd1;
    end
  end

  assign bus.KirbyX                     = x;
  assign bus.KirbyY                     = y;
  assign bus.character_action_idx       = state;
  assign bus.character_action_frame_idx = frame;
  assign bus.facing_left                = facing;
  assign bus.frame_tick                 = tick;

endmodule

// File: tb/tb_kirby_action_ctrl.sv
// Directed bench for kirby_action_ctrl: power-up fall, jump arc, clamps,
// animation, inhale, tick timing and asynchronous reset.
module tb_kirby_action_ctrl;
  import kirby_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  kirby_action_ctrl_if bus ();

  kirby_action_ctrl #(
    .X_START(10'd210),
    .Y_START(10'd240)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: raise frame_clk, wait (bounded) for the pulse, let the load edge pass.
  task automatic tick();
    int n;
    n = 0;
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    while (bus.frame_tick !== 1'b1 && n < 8) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("tick_seen", (n < 8) ? 16'd1 : 16'd0, 16'd1);
    @(posedge Clk);
    #1;
    bus.frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  int fall_y [15] = '{241, 243, 246, 250, 255, 261, 268, 276, 284, 292, 300, 308, 316, 324, 327};
  int jump_y [16] = '{319, 312, 306, 301, 297, 294, 292, 291, 292, 294, 297, 301, 306, 312, 319, 327};
  int left_x [5]  = '{208, 206, 204, 203, 203};

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, pulses;
    Reset         = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode   = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_x", bus.KirbyX, 16'd210);
    check("rst_y", bus.KirbyY, 16'd240);
    check("rst_act", bus.character_action_idx, 16'd0);
    check("rst_frame", bus.character_action_frame_idx, 16'd0);
    check("rst_facing", bus.facing_left, 16'd0);
    check("rst_tick", bus.frame_tick, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // first frame doubles as the tick latency / width / uniqueness check
    lat = 0;
    pulses = 0;
    bus.frame_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge Clk);
      #1;
      if (bus.frame_tick === 1'b1) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (i == 4) begin
        check("tick1_act", bus.character_action_idx, 16'(FALL));
        check("tick1_y", bus.KirbyY, 16'd240);
      end
    end
    check("tick_latency", 16'(lat), 16'd3);
    check("tick_pulses", 16'(pulses), 16'd1);
    bus.frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      tick();
      check("fall_y", bus.KirbyY, 16'(fall_y[i]));
      check("fall_act", bus.character_action_idx, (i == 14) ? 16'(IDLE) : 16'(FALL));
    end

    bus.keycode = KEY_JUMP;
    tick();
    check("jump_start_act", bus.character_action_idx, 16'(JUMP));
    check("jump_start_y", bus.KirbyY, 16'd327);
    bus.keycode = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("jump_y", bus.KirbyY, 16'(jump_y[i]));
      check("jump_act", bus.character_action_idx,
            (i < 7) ? 16'(JUMP) : (i < 15) ? 16'(FALL) : 16'(IDLE));
    end

    bus.keycode = KEY_LEFT;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("left_x", bus.KirbyX, 16'(left_x[i]));
      check("left_facing", bus.facing_left, 16'd1);
      check("left_act", bus.character_action_idx, 16'(WALK));
      check("left_frame", bus.character_action_frame_idx, (i == 4) ? 16'd1 : 16'd0);
    end
    bus.keycode = 8'h00;
    tick();
    check("stop_act", bus.character_action_idx, 16'(IDLE));
    check("stop_frame", bus.character_action_frame_idx, 16'd0);

    bus.keycode = KEY_RIGHT;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("walk_frame", bus.character_action_frame_idx, 16'((i / 4) % 8));
      check("walk_x", bus.KirbyX, 16'(203 + 2 * (i + 1)));
    end
    check("walk_act", bus.character_action_idx, 16'(WALK));
    check("walk_facing", bus.facing_left, 16'd0);
    bus.keycode = 8'h00;
    tick();

    bus.keycode = KEY_INHALE;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("inhale_frame", bus.character_action_frame_idx, 16'((i / 4 > 5) ? 5 : i / 4));
      check("inhale_x", bus.KirbyX, 16'd283);
      check("inhale_y", bus.KirbyY, 16'd327);
    end
    check("inhale_act", bus.character_action_idx, 16'(INHALE));
    bus.keycode = 8'h00;
    tick();
    check("release_act", bus.character_action_idx, 16'(IDLE));
    check("release_frame", bus.character_action_frame_idx, 16'd0);

    bus.keycode = 8'h55;
    tick();
    check("unknown_act", bus.character_action_idx, 16'(IDLE));
    check("unknown_x", bus.KirbyX, 16'd283);

    bus.keycode = KEY_JUMP;
    tick();
    bus.keycode = 8'h00;
    tick();
    tick();
    check("midjump_y", bus.KirbyY, 16'd312);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_x", bus.KirbyX, 16'd210);
    check("async_rst_y", bus.KirbyY, 16'd240);
    check("async_rst_act", bus.character_action_idx, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    tick();
    check("post_rst_act", bus.character_action_idx, 16'(FALL));
    check("post_rst_y", bus.KirbyY, 16'd240);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/kirby_action_ctrl.md
Name: kirby_action_ctrl

Overview:
Per-frame controller that sequences Kirby's sprite datapath. It decodes the keyboard keycode into an action state machine (idle, walk, jump, fall, inhale), integrates position with simple gravity and clamps it to the play window. It drives the action index, animation frame index and position consumed by the Kirby sprite/draw logic. Sits between the keyboard interface and the Kirby sprite block; all state advances once per frame_clk rising edge.

Parameters:
X_START, 10'd210, reset X position
Y_START, 10'd240, reset Y position (airborne, so Kirby falls to ground after reset)
X_MIN / X_MAX, 10'd203 / 10'd436, horizontal clamp limits
Y_MIN / Y_MAX, 10'd152 / 10'd327, vertical clamp limits; Y_MAX is ground
MOVE_STEP, 10'd2, horizontal pixels per frame
JUMP_V0, 4'd8, initial upward velocity
FALL_VMAX, 4'd8, terminal fall velocity
FRAME_DIV, 3'd4, frame ticks per animation frame
KEY_LEFT / KEY_RIGHT / KEY_JUMP / KEY_INHALE, 8'h04 / 8'h07 / 8'h1A / 8'h0D, HID codes A, D, W, J

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  ~60 Hz frame strobe (asynchronous to Clk)
keycode  in  8  currently pressed key, 8'h00 = none
KirbyX  out  10  Kirby X position
KirbyY  out  10  Kirby Y position
character_action_idx  out  3  0 IDLE, 1 WALK, 2 JUMP, 3 FALL, 4 INHALE
character_action_frame_idx  out  4  animation frame within action
facing_left  out  1  1 = sprite mirrored (last horizontal key was LEFT)
frame_tick  out  1  one-Clk pulse per frame_clk rising edge (debug/verification)

Behaviour:
- Reset (async, immediate): KirbyX=X_START, KirbyY=Y_START, state IDLE, action_idx 0, frame_idx 0, div counter 0, vy=0, vf=0, facing_left 0, frame_tick 0, sync flops 0.
- frame_tick: frame_clk goes through a 2-flop synchroniser, then a rising-edge detect. frame_tick is high exactly 1 Clk cycle and is registered 3 Clk edges after frame_clk rises. All state, position and animation registers load only on the Clk edge where frame_tick=1; outputs change 1 Clk after that.
- keycode is sampled on the tick edge only.
- Horizontal movement (IDLE/WALK/JUMP/FALL, not INHALE):
  - KEY_LEFT: X=max(X-MOVE_STEP, X_MIN) and facing_left=1.
  - KEY_RIGHT: X=min(X+MOVE_STEP, X_MAX) and facing_left=0.
  - Arithmetic in 11 bits; no wrap.
- IDLE/WALK:
  - If Y<Y_MAX -> FALL, vf=1, no Y move this tick.
  - Else KEY_JUMP -> JUMP, vy=JUMP_V0.
  - Else KEY_INHALE -> INHALE.
  - Else KEY_LEFT/KEY_RIGHT -> WALK.
  - Else -> IDLE.
- JUMP: Y=Y-vy, then vy=vy-1.
  - If new vy==0 -> FALL, vf=1.
  - If Y-vy<Y_MIN: Y=Y_MIN -> FALL, vf=1.
  - Releasing KEY_JUMP does not shorten the jump.
- FALL: Y=Y+vf, then vf=min(vf+1, FALL_VMAX).
  - If Y+vf>=Y_MAX: Y=Y_MAX, vf=0, next state WALK if KEY_LEFT/KEY_RIGHT is held, else IDLE.
- INHALE: X/Y frozen. Stays while keycode==KEY_INHALE; any other keycode -> IDLE.
- Animation frame counts: IDLE 2, WALK 8, JUMP 4, FALL 2, INHALE 6.
  - div counter counts ticks 0..FRAME_DIV-1; at FRAME_DIV-1 frame_idx advances.
  - frame_idx wraps to 0 after the last frame, except INHALE, which saturates at 5.
  - Any state change: frame_idx=0, div=0 on that tick.
- Unknown keycodes are treated as 8'h00.
- Reset asserted mid-jump returns everything to reset values asynchronously; the first tick after release follows the IDLE rules.

Decomposition:
- Package kirby_pkg:
  - action enum (IDLE..INHALE, 3 bits)
  - HID keycode constants
  - per-action frame-count localparams
- Sub-module kirby_frame_tick: frame_clk synchroniser plus rising-edge pulse generator.
- The FSM and physics stay in kirby_action_ctrl.

Test Plan:
- Power-up fall: Reset, no keys, tick. 1st tick -> FALL with Y=240. Y then follows 241,243,246,250,255,261,268,276,...,324. Landing tick gives Y=327 and IDLE, 16 ticks after reset.
- Jump arc: grounded at Y=327, KEY_JUMP for 1 tick. Y follows 319,312,306,301,297,294,292,291 (-> FALL), then 292,294,297,301,306,312,319,327 -> IDLE. action_idx is 2, then 3, then 0.
- Left clamp: X=210, hold KEY_LEFT 5 ticks. X = 208,206,204,203,203; facing_left=1; action WALK.
- Walk animation: hold KEY_RIGHT 40 ticks from IDLE. frame_idx increments every 4 ticks: 0..7, then wraps to 0 at tick 32.
- Inhale: KEY_INHALE 30 ticks. X/Y are constant; frame_idx goes 0..5 and holds 5. Releasing the key -> IDLE with frame_idx 0.
- Tick timing / reset: check frame_tick width is 1 Clk, latency is 3 Clk, and exactly one pulse per frame_clk edge. Assert Reset mid-jump: X=210, Y=240, action 0 immediately, without waiting for Clk.
